// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID pipeline register.
// Handles stalls from the hazard unit and PC redirects resolved in ID.
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_3000,
  parameter int          DELAY_SLOT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        id_redirect,
  input  logic [31:0] id_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc8,
  output logic        id_valid,
  output logic [31:0] fetch_count
);

  logic [31:0] r_pc;
  logic [31:0] r_idInstr;
  logic [31:0] r_idPc;
  logic [31:0] r_idPc8;
  logic        r_idValid;
  logic [31:0] r_fetchCount;

  logic [31:0] w_pcPlus4;
  logic [31:0] w_pcPlus8;
  logic [31:0] w_redirectPc;
  logic        w_squash;

  assign w_pcPlus4    = r_pc + 32'd4;
  assign w_pcPlus8    = r_pc + 32'd8;
  assign w_redirectPc = {id_target[31:2], 2'b00};
  assign w_squash     = id_redirect && (DELAY_SLOT == 0);

  // A stall freezes everything, including a pending redirect: ID re-presents it next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_PC;
      r_idInstr    <= 32'd0;
      r_idPc       <= 32'd0;
      r_idPc8      <= 32'd0;
      r_idValid    <= 1'b0;
      r_fetchCount <= 32'd0;
    end else if (!stall) begin
      r_pc    <= id_redirect ? w_redirectPc : w_pcPlus4;
      r_idPc  <= r_pc;
      r_idPc8 <= w_pcPlus8;
      if (w_squash) begin
        r_idInstr <= 32'd0;
        r_idValid <= 1'b0;
      end else begin
        r_idInstr    <= imem_rdata;
        r_idValid    <= 1'b1;
        r_fetchCount <= r_fetchCount + 32'd1;
      end
    end
  end

  assign imem_addr   = r_pc;
  assign id_instr    = r_idInstr;
  assign id_pc       = r_idPc;
  assign id_pc8      = r_idPc8;
  assign id_valid    = r_idValid;
  assign fetch_count = r_fetchCount;

endmodule
